// File: rtl/regfile_sb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : regfile_sb_pkg                                               |
// | Description : Shared constants for the register file and its scoreboard.   |
// |               Optional build macro: REGFILE_WB_BYPASS_EN.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package regfile_sb_pkg;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
// +----------------------------------------------------------------------------+
// | Module      : rf_scoreboard                                                |
// | Description : Busy-bit scoreboard with set/clear/flush priority, busy      |
// |               lookups and issue stall. Macro: REGFILE_WB_BYPASS_EN.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module rf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mark_valid,
  input  logic [ADDR_W-1:0] mark_rd,
  input  logic              flush,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              hazard_stall
);
  import regfile_sb_pkg::*;

  logic [NUM_REGS-1:1] r_busy;
  logic [NUM_REGS-1:1] w_busy_nxt;
  logic [NUM_REGS-1:0] w_busy;

  assign w_busy = {r_busy, 1'b0};

  // Mark is applied after clear so a new producer supersedes a completing one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (clr_valid && (clr_rd == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b0;
      if (mark_valid && (mark_rd == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b1;
    end
    if (flush)
      w_busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic w_rs1_clr;
  logic w_rs2_clr;

  assign w_rs1_clr = clr_valid && (clr_rd == rs1_addr)
                     && !(mark_valid && (mark_rd == rs1_addr));
  assign w_rs2_clr = clr_valid && (clr_rd == rs2_addr)
                     && !(mark_valid && (mark_rd == rs2_addr));
  assign rs1_busy  = w_busy[rs1_addr] && !w_rs1_clr;
  assign rs2_busy  = w_busy[rs2_addr] && !w_rs2_clr;
`else
  assign rs1_busy  = w_busy[rs1_addr];
  assign rs2_busy  = w_busy[rs2_addr];
`endif

  // WAW term keeps at most one outstanding producer per register.
  assign hazard_stall = rs1_busy || rs2_busy || (mark_valid && w_busy[mark_rd]);

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// +----------------------------------------------------------------------------+
// | Module      : regfile_sb                                                   |
// | Description : Integer register file (x0 = 0), two combinational read ports |
// |               and busy scoreboard. Macro: REGFILE_WB_BYPASS_EN.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_sb #(
  parameter int DATA_WIDTH = regfile_sb_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = regfile_sb_pkg::NUM_REGS,
  parameter int ADDR_W     = regfile_sb_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_we,
  input  logic [ADDR_W-1:0]     wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  mark_valid,
  input  logic [ADDR_W-1:0]     mark_rd,
  input  logic                  flush,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  hazard_stall
);
  import regfile_sb_pkg::*;

  logic                  w_wb_fire;
  logic [DATA_WIDTH-1:0] r_regs  [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] w_rd_arr [NUM_REGS];

  assign w_wb_fire   = wb_we && (wb_rd != REG_ZERO);
  assign w_rd_arr[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_regs[gi] <= '0;
        else if (w_wb_fire && (wb_rd == ADDR_W'(gi)))
          r_regs[gi] <= wb_wdata;
      end
      assign w_rd_arr[gi] = r_regs[gi];
    end
  endgenerate

`ifdef REGFILE_WB_BYPASS_EN
  // Forwarding is suppressed in reset so the read ports stay at zero.
  logic w_fwd_en;

  assign w_fwd_en = w_wb_fire && rst_n;
  assign rs1_data = (w_fwd_en && (wb_rd == rs1_addr)) ? wb_wdata : w_rd_arr[rs1_addr];
  assign rs2_data = (w_fwd_en && (wb_rd == rs2_addr)) ? wb_wdata : w_rd_arr[rs2_addr];
`else
  assign rs1_data = w_rd_arr[rs1_addr];
  assign rs2_data = w_rd_arr[rs2_addr];
`endif

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .mark_valid   (mark_valid),
    .mark_rd      (mark_rd),
    .flush        (flush),
    .clr_valid    (w_wb_fire),
    .clr_rd       (wb_rd),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .hazard_stall (hazard_stall)
  );

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Architectural integer register file with an attached busy-bit scoreboard.
- Receiver end of the writeback interface: consumes the gated write enable, destination index and write data produced by the writeback select stage.
- Serves two combinational read ports to decode/issue.
- Tracks registers with an outstanding long-latency producer (loads) and raises an issue stall on RAW/WAW hazards.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): register width.
- NUM_REGS, 32: register count; x0 hardwired to zero.
- ADDR_W, 5: register index width; must equal clog2(NUM_REGS).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_we  in  1  gated write enable from writeback (already kill- and x0-gated)
- wb_rd  in  ADDR_W  writeback destination index
- wb_wdata  in  DATA_WIDTH  writeback data
- rs1_addr  in  ADDR_W  read port 1 index
- rs2_addr  in  ADDR_W  read port 2 index
- rs1_data  out  DATA_WIDTH  read port 1 data (combinational)
- rs2_data  out  DATA_WIDTH  read port 2 data (combinational)
- mark_valid  in  1  issuing instruction is a long-latency producer of mark_rd
- mark_rd  in  ADDR_W  destination to mark busy
- flush  in  1  trap/redirect: abandon all outstanding producers
- rs1_busy  out  1  rs1_addr has an outstanding producer
- rs2_busy  out  1  rs2_addr has an outstanding producer
- hazard_stall  out  1  rs1_busy | rs2_busy | (mark_valid & busy[mark_rd])

Behaviour:
- Reset (rst_n low, asynchronous): all registers clear to 0; all busy bits clear to 0.
- Outputs during reset: rs*_data = 0, rs*_busy = 0, hazard_stall = 0.
- Reset release mid-operation: no pending state survives; the first edge after release behaves as a normal cycle.
- Write: on rising edge, if wb_we and wb_rd != 0, then reg[wb_rd] <= wb_wdata.
  - wb_rd == 0 is ignored even if wb_we = 1 (defensive; upstream already gates this).
- Read: combinational.
  - rsN_data = 0 when rsN_addr == 0, else reg[rsN_addr].
  - Latency: a write at edge N is visible on the read ports after edge N (see Optional Feature for same-cycle behaviour).
- Scoreboard, per-register busy bit, updated at the rising edge:
  - Set: mark_valid & !flush & mark_rd != 0 -> busy[mark_rd] <= 1.
  - Clear: wb_we & wb_rd != 0 -> busy[wb_rd] <= 0.
  - Same index marked and cleared in one cycle: set wins; the new producer supersedes the completing one.
  - Different indices marked and cleared in one cycle: both take effect.
  - flush: all busy bits <= 0, overriding any set in the same cycle. A wb_we write in the flush cycle still updates register data.
  - A writeback to a non-busy register is legal (single-cycle ALU/JAL results) and only writes data.
  - busy[0] is constant 0.
- Busy outputs: rsN_busy = busy[rsN_addr], combinational, 0 for index 0.
  - With WB_BYPASS_EN, a register being cleared by the current writeback reads as not busy.
- hazard_stall: combinational.
  - Issue must hold the instruction while high.
  - This block does not gate mark_valid on stall; issue must drive mark_valid = 0 while stalled.
- There is no FIFO; at most one outstanding producer per register. The WAW term in hazard_stall enforces this.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Write-through read. If wb_we & wb_rd != 0 & wb_rd == rsN_addr, then rsN_data = wb_wdata in the same cycle.
  - rsN_busy for that index reads 0 in that cycle unless mark_valid targets the same index.
  - Result: zero-bubble writeback-to-decode.
- Not defined:
  - Reads return the pre-write value in the write cycle.
  - Busy bits reflect the registered state only.
  - Issue sees the result one cycle later.

Decomposition:
- Shared package/defines: DATA_WIDTH, REG_ADDR_W = 5, NUM_REGS = 32, REG_ZERO = 5'd0.
- Natural sub-module: rf_scoreboard. It holds the busy vector, set/clear/flush priority, busy lookups and hazard_stall.
- The top level holds the storage array, read muxes and bypass logic.

Test Plan:
- Reset then read: rst_n low mid-run after writing x5 = 0xDEADBEEF -> rs1_data = 0 and all busy = 0 immediately, asynchronously.
- Write/read: wb_we = 1, wb_rd = 7, wb_wdata = 0x12345678 -> rs1_addr = 7 reads 0x12345678 next cycle. Same-cycle read returns the old value without the macro and 0x12345678 with it.
- x0 protection: wb_we = 1, wb_rd = 0, wb_wdata = 0xFFFFFFFF; mark_valid with mark_rd = 0 -> rs1_data(0) = 0, rs1_busy = 0.
- Load hazard: mark_valid, mark_rd = 3; next cycle rs2_addr = 3 -> rs2_busy = 1, hazard_stall = 1. Writeback to x3 = 0x55 -> busy clears the following cycle and rs2_data = 0x55.
- Simultaneous mark/clear: busy[9] = 1; same cycle wb_we to x9 and mark_valid to x9 -> busy[9] stays 1 and data updates.
- Flush: busy[4] and busy[6] set; flush = 1 together with mark_valid to x8 -> all busy bits 0 next cycle, including x8.
